mem_access: RTL
===============

# mem_access

Memory-access stage between the EX/MEM pipeline latch and the MEM/WB latch. It passes ALU results straight through and runs a registered request/acknowledge transaction to data memory for loads and stores. It holds the upstream pipeline while a transaction is outstanding. Loads are aligned and extended by byte-lane select; stores are lane-shifted.

## Interface
- `RegAddrWidth`, 5, register address width
- `RegDataWidth`, 32, data/address width
- `ByteSlctWidth`, 4, byte-lane select width
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `target_MEM`, `WriteReg_MEM`, `MemOrAlu_MEM`, `ReadMem_MEM`, `WriteMem_MEM`  in  5/1/1/1/1  EX/MEM latch controls
- `data_from_ALU_MEM`  in  32  ALU result, or effective address for memory ops
- `rdata_2_MEM`  in  32  store data
- `byte_slct_MEM`  in  4  active byte lanes
- `load_sign_MEM`  in  1  1 = sign-extend load, 0 = zero-extend
- `mem_req`  out  1  registered bus request
- `mem_we`  out  1  write strobe, valid with mem_req
- `mem_addr`  out  32  word address {addr[31:2],2'b00}
- `mem_be`  out  4  byte enables = byte_slct_MEM
- `mem_wdata`  out  32  lane-shifted store data
- `mem_rdata`  in  32  read data, valid with mem_ack
- `mem_ack`  in  1  one-cycle completion pulse
- `hold_req`  out  1  stall to the upstream latches' is_hold inputs
- `target_WB`  out  5  destination register
- `WriteReg_WB`  out  1  register write enable to MEM/WB
- `data_WB`  out  32  ALU result or aligned load data
- `addr_err`  out  1  one-cycle illegal-lane-pattern flag

## Operation
- FSM states: IDLE, WAIT, DONE. Reset puts it in IDLE with mem_req=0, mem_we=0, the load buffer at 0, and addr_err=0.
- Legal byte_slct values are 0001, 0010, 0100, 1000, 0011, 1100 and 1111. Lane offset k is the index of the lowest set bit.
- IDLE with neither ReadMem_MEM nor WriteMem_MEM asserted:
  - Passthrough: data_WB=data_from_ALU_MEM, WriteReg_WB=WriteReg_MEM, hold_req=0.
- IDLE with a memory op and a legal select:
  - hold_req=1 combinationally.
  - On the next edge, register mem_req=1, mem_we=WriteMem_MEM, mem_addr, mem_be, and mem_wdata=rdata_2_MEM<<(8k). Go to WAIT.
- IDLE with a memory op and an illegal select:
  - No request is issued. addr_err=1 for that cycle, WriteReg_WB=0, hold_req=0.
- ReadMem_MEM and WriteMem_MEM both asserted is treated as a store.
- WAIT: hold_req=1, WriteReg_WB=0, and mem_req stays high with all request fields stable.
  - mem_ack while in WAIT: drop mem_req on that edge, latch mem_rdata into the load buffer, go to DONE.
  - mem_ack in IDLE or DONE is ignored.
- DONE: hold_req=0. WriteReg_WB=WriteReg_MEM & ReadMem_MEM (stores never write).
  - data_WB is the buffered data shifted right by 8k. It is masked to the lane width (8/16/32) and sign- or zero-extended per load_sign_MEM.
  - Go to IDLE on the next edge.
- target_WB equals target_MEM in every state.
- rst low at any time forces IDLE asynchronously, drops mem_req at once, and abandons any outstanding transaction.

## Timing
- ALU op: zero added latency, purely combinational.
- Memory op presented in cycle 0:
  - mem_req is high from cycle 1.
  - If mem_ack arrives in cycle n (n≥1), DONE is cycle n+1.
  - hold_req is high in cycles 0..n.
  - The result is valid in DONE and is captured by MEM/WB at the end of cycle n+1.
- Minimum memory-op occupancy is 3 cycles (ack in cycle 1).
- hold_req never depends on mem_ack combinationally; it is a function of state and the current inputs only.

## Test plan
- Reset held low, then released with ALU op data=0x1234, WriteReg=1 -> mem_req=0, hold_req=0, same-cycle data_WB=0x1234, WriteReg_WB=1.
- Load word, addr 0x100, be=1111, ack in cycle 1 with rdata 0xDEADBEEF:
  - mem_req in cycle 1 only; hold_req in cycles 0–1.
  - DONE in cycle 2 with data_WB=0xDEADBEEF.
- Signed byte load, addr 0x103, be=1000, rdata 0x80FF_FFFF -> data_WB=0xFFFFFF80. Unsigned repeat -> 0x00000080.
- Halfword store, be=1100, rdata_2=0x0000ABCD, ack delayed 4 cycles:
  - mem_wdata=0xABCD0000, mem_we=1.
  - Request fields stable for all 4 cycles; WriteReg_WB=0 in DONE.
- Illegal be=0101 with ReadMem -> no mem_req, addr_err pulse of 1 cycle, hold_req=0. Spurious mem_ack in IDLE -> no state change.
- rst asserted in WAIT -> mem_req and hold_req fall immediately. After release, the FSM is in IDLE and a late mem_ack is ignored.

Source files
------------

// File: rtl/mem_access_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_if
// Description : Data-memory request/acknowledge bus between the memory-access
//               stage (master) and the data memory (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_if #(
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = 4
);
    logic                  mem_req;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [BE_WIDTH-1:0]   mem_be;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module      : mem_access
// Description : Pipeline memory-access stage. ALU results pass straight
//               through; loads/stores run a registered req/ack transaction,
//               stall upstream while outstanding, and align load data by
//               byte-lane select.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access #(
    parameter int RegAddrWidth  = 5,
    parameter int RegDataWidth  = 32,
    parameter int ByteSlctWidth = 4
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic [RegAddrWidth-1:0]  target_MEM,
    input  wire logic                     WriteReg_MEM,
    input  wire logic                     MemOrAlu_MEM,
    input  wire logic                     ReadMem_MEM,
    input  wire logic                     WriteMem_MEM,
    input  wire logic [RegDataWidth-1:0]  data_from_ALU_MEM,
    input  wire logic [RegDataWidth-1:0]  rdata_2_MEM,
    input  wire logic [ByteSlctWidth-1:0] byte_slct_MEM,
    input  wire logic                     load_sign_MEM,
    mem_access_if.master                  mem,
    output logic                          hold_req,
    output logic [RegAddrWidth-1:0]       target_WB,
    output logic                          WriteReg_WB,
    output logic [RegDataWidth-1:0]       data_WB,
    output logic                          addr_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [1:0] c_W_BYTE = 2'd0;
    localparam logic [1:0] c_W_HALF = 2'd1;
    localparam logic [1:0] c_W_WORD = 2'd2;

    // Only naturally aligned byte, halfword and word lane patterns are legal.
    function automatic logic lane_legal(input logic [ByteSlctWidth-1:0] slct);
        case (slct)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: lane_legal = 1'b1;
            default:                   lane_legal = 1'b0;
        endcase
    endfunction

    // Index of the lowest active lane.
    function automatic logic [1:0] lane_offset(input logic [ByteSlctWidth-1:0] slct);
        if (slct[0])      lane_offset = 2'd0;
        else if (slct[1]) lane_offset = 2'd1;
        else if (slct[2]) lane_offset = 2'd2;
        else              lane_offset = 2'd3;
    endfunction

    function automatic logic [1:0] lane_width(input logic [ByteSlctWidth-1:0] slct);
        case (slct)
            4'b0011, 4'b1100: lane_width = c_W_HALF;
            4'b1111:          lane_width = c_W_WORD;
            default:          lane_width = c_W_BYTE;
        endcase
    endfunction

    state_e                   state_q, state_d;
    logic                     mem_req_q, mem_req_d;
    logic                     mem_we_q, mem_we_d;
    logic [RegDataWidth-1:0]  mem_addr_q, mem_addr_d;
    logic [ByteSlctWidth-1:0] mem_be_q, mem_be_d;
    logic [RegDataWidth-1:0]  mem_wdata_q, mem_wdata_d;
    logic [RegDataWidth-1:0]  load_buf_q, load_buf_d;

    logic                     w_mem_op;
    logic [4:0]               w_st_shamt;
    logic [4:0]               w_ld_shamt;
    logic [1:0]               w_ld_width;
    logic [RegDataWidth-1:0]  w_ld_shifted;
    logic [RegDataWidth-1:0]  w_ld_aligned;
    logic                     w_hold;
    logic                     w_addr_err;

    assign w_mem_op   = ReadMem_MEM | WriteMem_MEM;
    assign w_st_shamt = {lane_offset(byte_slct_MEM), 3'b000};

    // Align buffered load data using the lane pattern that was actually issued.
    always_comb begin
        w_ld_shamt   = {lane_offset(mem_be_q), 3'b000};
        w_ld_width   = lane_width(mem_be_q);
        w_ld_shifted = load_buf_q >> w_ld_shamt;
        case (w_ld_width)
            c_W_BYTE: w_ld_aligned = {{(RegDataWidth-8){load_sign_MEM & w_ld_shifted[7]}},
                                      w_ld_shifted[7:0]};
            c_W_HALF: w_ld_aligned = {{(RegDataWidth-16){load_sign_MEM & w_ld_shifted[15]}},
                                      w_ld_shifted[15:0]};
            default:  w_ld_aligned = w_ld_shifted;
        endcase
    end

    // Next-state, request-field and writeback logic.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        load_buf_d  = load_buf_q;
        w_hold      = 1'b0;
        w_addr_err  = 1'b0;
        WriteReg_WB = WriteReg_MEM;
        data_WB     = data_from_ALU_MEM;
        case (state_q)
            S_IDLE: begin
                if (w_mem_op) begin
                    if (lane_legal(byte_slct_MEM)) begin
                        w_hold      = 1'b1;
                        state_d     = S_WAIT;
                        mem_req_d   = 1'b1;
                        mem_we_d    = WriteMem_MEM;
                        mem_addr_d  = {data_from_ALU_MEM[RegDataWidth-1:2], 2'b00};
                        mem_be_d    = byte_slct_MEM;
                        mem_wdata_d = rdata_2_MEM << w_st_shamt;
                    end else begin
                        w_addr_err  = 1'b1;
                        WriteReg_WB = 1'b0;
                    end
                end
            end
            S_WAIT: begin
                w_hold      = 1'b1;
                WriteReg_WB = 1'b0;
                if (mem.mem_ack) begin
                    mem_req_d  = 1'b0;
                    load_buf_d = mem.mem_rdata;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                // A store never writes back, including read+write, which is a store.
                WriteReg_WB = WriteReg_MEM & ReadMem_MEM & ~WriteMem_MEM;
                // A store decoded as an ALU-result instruction forwards the
                // address; its writeback is disabled so the value is inert.
                data_WB     = (WriteMem_MEM & ~MemOrAlu_MEM) ? data_from_ALU_MEM
                                                             : w_ld_aligned;
                state_d     = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and request registers; reset abandons any outstanding transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            load_buf_q  <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            load_buf_q  <= load_buf_d;
        end
    end

    // Stall and error flags are suppressed while reset is held.
    assign hold_req      = w_hold & rst;
    assign addr_err      = w_addr_err & rst;
    assign target_WB     = target_MEM;
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_be    = mem_be_q;
    assign mem.mem_wdata = mem_wdata_q;

endmodule
`default_nettype wire
